// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle between the EX-stage control and the
// iterative multiply/divide unit.
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output start, op, src_a, src_b, mthi, mtlo, wdata,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, src_a, src_b, mthi, mtlo, wdata,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Fixed 34-cycle sequence: accept, 32 iterations, sign fixup/writeback.
module muldiv_unit (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [1:0]  op_q;
  logic        neg_q, neg_r, div0;
  logic [31:0] opa, opb;
  logic [63:0] acc;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        is_div, launch_signed;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_trial;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  assign is_div        = op_q[1];
  assign launch_signed = ~bus.op[0];

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = CALC;
      CALC:    if (cnt == 5'd31) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Multiply keeps the product in acc (upper half accumulates, shifts right);
  // divide reuses acc[32:0] as the partial remainder and opa as dividend/quotient.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + {1'b0, (opb[0] ? opa : 32'd0)};
    div_shift = {acc[31:0], opa[31]};
    div_trial = {1'b0, div_shift} - {2'b00, opb};
    prod      = neg_q ? -acc : acc;
    quo       = (neg_q && !div0) ? -opa : opa;
    rem       = (neg_r && !div0) ? -acc[31:0] : acc[31:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q  <= bus.op;
            opa   <= (launch_signed && bus.src_a[31]) ? -bus.src_a : bus.src_a;
            opb   <= (launch_signed && bus.src_b[31]) ? -bus.src_b : bus.src_b;
            neg_q <= launch_signed && (bus.src_a[31] ^ bus.src_b[31]);
            neg_r <= launch_signed && bus.src_a[31];
            div0  <= (bus.src_b == 32'd0);
            acc   <= '0;
            cnt   <= '0;
          end else begin
            if (bus.mthi) hi_q <= bus.wdata;
            if (bus.mtlo) lo_q <= bus.wdata;
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            if (!div_trial[33]) begin
              acc <= {31'd0, div_trial[32:0]};
              opa <= {opa[30:0], 1'b1};
            end else begin
              acc <= {31'd0, div_shift};
              opa <= {opa[30:0], 1'b0};
            end
          end else begin
            acc <= {mul_sum, acc[31:1]};
            opb <= {1'b0, opb[31:1]};
          end
        end
        FIX: begin
          if (is_div) begin
            hi_q <= rem;
            lo_q <= quo;
          end else begin
            hi_q <= prod[63:32];
            lo_q <= prod[31:0];
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed test-plan cases plus random
// operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Architectural results from 64-bit host arithmetic; division truncates
  // toward zero with the remainder taking the dividend's sign.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rhi, output logic [31:0] rlo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rhi = '0;
    rlo = '0;
    case (o)
      2'd0: begin p = 64'(sa * sb); rhi = p[63:32]; rlo = p[31:0]; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; rhi = p[63:32]; rlo = p[31:0]; end
      2'd2: begin
        if (b == 32'd0) begin rlo = '1; rhi = a; end
        else begin q = sa / sb; r = sa % sb; rlo = q[31:0]; rhi = r[31:0]; end
      end
      default: begin
        if (b == 32'd0) begin rlo = '1; rhi = a; end
        else begin rlo = a / b; rhi = a % b; end
      end
    endcase
  endfunction

  // Launches one op from IDLE (called #1 after an edge), scrambles operands
  // after accept, and returns #1 after the edge where done is seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rhi, output logic [31:0] rlo,
                        output int done_edge, output int busy_cnt, output bit early);
    logic [31:0] hi0, lo0;
    hi0 = bus.hi;
    lo0 = bus.lo;
    bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 2'($urandom); bus.src_a = $urandom; bus.src_b = $urandom;
    busy_cnt  = bus.busy ? 1 : 0;
    done_edge = 0;
    early     = 1'b0;
    rhi       = bus.hi;
    rlo       = bus.lo;
    for (int e = 1; e <= 40 && done_edge == 0; e++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_edge = e;
        rhi = bus.hi;
        rlo = bus.lo;
      end else if (bus.hi !== hi0 || bus.lo !== lo0) begin
        early = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.hi !== 32'd0) $display("FAIL reset_hi got %h want 0", bus.hi); else passed++;
    total++; if (bus.lo !== 32'd0) $display("FAIL reset_lo got %h want 0", bus.lo); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult_timing;
    logic [31:0] h, l;
    int de, bc;
    bit early;
    run_op(2'd0, 32'hFFFFFFFD, 32'd5, h, l, de, bc, early);
    total++; if (h !== 32'hFFFFFFFF) $display("FAIL mult_hi got %h want ffffffff", h); else passed++;
    total++; if (l !== 32'hFFFFFFF1) $display("FAIL mult_lo got %h want fffffff1", l); else passed++;
    total++; if (de != 33) $display("FAIL mult_done_edge got %0d want 33", de); else passed++;
    total++; if (bc != 33) $display("FAIL mult_busy_cycles got %0d want 33", bc); else passed++;
    total++; if (early !== 1'b0) $display("FAIL mult_hilo_hold got %b want 0", early); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL mult_busy_at_done got %b want 0", bus.busy); else passed++;
    @(posedge clk); #1;
    total++; if (bus.done !== 1'b0) $display("FAIL mult_done_pulse got %b want 0", bus.done); else passed++;
  endtask

  task automatic test_directed;
    logic [1:0]  ops [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
    logic [31:0] as  [4] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'h80000000};
    logic [31:0] bs  [4] = '{32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF};
    logic [31:0] eh  [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000064, 32'h00000000};
    logic [31:0] el  [4] = '{32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] h, l;
    int de, bc;
    bit early;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], h, l, de, bc, early);
      total++; if (h !== eh[i]) $display("FAIL directed%0d_hi got %h want %h", i, h, eh[i]); else passed++;
      total++; if (l !== el[i]) $display("FAIL directed%0d_lo got %h want %h", i, l, el[i]); else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a, b, h, l, mh, ml;
    int de, bc;
    bit early;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if (o == 2'd2 && b == 32'd0) b = 32'd3;
      ref_model(o, a, b, mh, ml);
      run_op(o, a, b, h, l, de, bc, early);
      total++;
      if (h !== mh || l !== ml || de != 33)
        $display("FAIL random%0d op=%0d a=%h b=%h got hi=%h lo=%h edge=%0d want hi=%h lo=%h edge=33",
                 i, o, a, b, h, l, de, mh, ml);
      else passed++;
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] h1, l1, h2, l2, mh, ml;
    int de1, de2, bc;
    bit early;
    run_op(2'd1, 32'd123456, 32'd789, h1, l1, de1, bc, early);
    run_op(2'd3, 32'd1000003, 32'd17, h2, l2, de2, bc, early);
    ref_model(2'd1, 32'd123456, 32'd789, mh, ml);
    total++; if ({h1, l1} !== {mh, ml}) $display("FAIL b2b_first got %h%h want %h%h", h1, l1, mh, ml); else passed++;
    ref_model(2'd3, 32'd1000003, 32'd17, mh, ml);
    total++; if ({h2, l2} !== {mh, ml}) $display("FAIL b2b_second got %h%h want %h%h", h2, l2, mh, ml); else passed++;
    total++; if (de2 != 33) $display("FAIL b2b_second_edge got %0d want 33", de2); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_inputs;
    int de;
    de = 0;
    bus.start = 1'b1; bus.op = 2'd1; bus.src_a = 32'd3; bus.src_b = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int e = 1; e <= 40 && de == 0; e++) begin
      @(posedge clk); #1;
      if (bus.done) de = e;
      if (e == 9) begin
        bus.start = 1'b1; bus.op = 2'd2; bus.src_a = $urandom; bus.src_b = $urandom;
        bus.mthi = 1'b1; bus.wdata = 32'h0000DEAD;
      end else if (e == 10) begin
        bus.start = 1'b0; bus.mthi = 1'b0;
      end
    end
    total++; if (de != 33) $display("FAIL ignore_done_edge got %0d want 33", de); else passed++;
    total++; if (bus.hi !== 32'd0) $display("FAIL ignore_hi got %h want 0", bus.hi); else passed++;
    total++; if (bus.lo !== 32'd12) $display("FAIL ignore_lo got %h want c", bus.lo); else passed++;
    bus.mthi = 1'b1; bus.mtlo = 1'b0; bus.wdata = 32'h1234;
    @(posedge clk); #1;
    bus.mthi = 1'b0;
    total++; if (bus.busy !== 1'b0) $display("FAIL ignore_no_restart got %b want 0", bus.busy); else passed++;
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h5678;
    @(posedge clk); #1;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    // Second write overlays HI; use separate values to see both paths.
    bus.mthi = 1'b1; bus.wdata = 32'h1234;
    @(posedge clk); #1;
    bus.mthi = 1'b0;
    total++; if (bus.hi !== 32'h1234) $display("FAIL mt_both_hi got %h want 1234", bus.hi); else passed++;
    total++; if (bus.lo !== 32'h5678) $display("FAIL mt_both_lo got %h want 5678", bus.lo); else passed++;
    bus.start = 1'b1; bus.op = 2'd1; bus.src_a = 32'd7; bus.src_b = 32'd6;
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hAAAA;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    total++;
    if (bus.hi !== 32'h1234 || bus.lo !== 32'h5678 || bus.busy !== 1'b1)
      $display("FAIL start_beats_mt got hi=%h lo=%h busy=%b want hi=1234 lo=5678 busy=1", bus.hi, bus.lo, bus.busy);
    else passed++;
    de = 0;
    for (int e = 1; e <= 40 && de == 0; e++) begin
      @(posedge clk); #1;
      if (bus.done) de = e;
    end
    total++;
    if (de != 33 || bus.hi !== 32'd0 || bus.lo !== 32'd42)
      $display("FAIL start_beats_mt_result got edge=%0d hi=%h lo=%h want edge=33 hi=0 lo=2a", de, bus.hi, bus.lo);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] h, l;
    int de, bc, seen;
    bit early;
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h00000011;
    @(posedge clk); #1;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    total++; if (bus.hi !== 32'h11 || bus.lo !== 32'h11) $display("FAIL preload got hi=%h lo=%h want 11", bus.hi, bus.lo); else passed++;
    bus.start = 1'b1; bus.op = 2'd3; bus.src_a = 32'd5000; bus.src_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL midreset got hi=%h lo=%h busy=%b done=%b want all 0", bus.hi, bus.lo, bus.busy, bus.done);
    else passed++;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen++;
    end
    total++; if (seen != 0) $display("FAIL midreset_no_done got %0d want 0", seen); else passed++;
    run_op(2'd0, 32'd2, 32'd3, h, l, de, bc, early);
    total++; if (h !== 32'd0 || l !== 32'd6) $display("FAIL after_reset_mult got hi=%h lo=%h want 0/6", h, l); else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_mult_timing();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignored_inputs();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
